// File: rtl/mem_port_arbiter_if.sv
// Request/grant/valid bundle between the fetch and data requesters, the
// shared single-ported memory, and the arbiter that serialises them.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_pi;
  logic [ADDR_W-1:0] if_addr_pi;
  logic              if_gnt_po;
  logic              if_valid_po;
  logic [DATA_W-1:0] if_rdata_po;

  logic              d_req_pi;
  logic              d_we_pi;
  logic [ADDR_W-1:0] d_addr_pi;
  logic [DATA_W-1:0] d_wdata_pi;
  logic              d_gnt_po;
  logic              d_valid_po;
  logic [DATA_W-1:0] d_rdata_po;

  logic              mem_en_po;
  logic              mem_we_po;
  logic [ADDR_W-1:0] mem_addr_po;
  logic [DATA_W-1:0] mem_wdata_po;
  logic [DATA_W-1:0] mem_rdata_pi;
  logic              mem_ready_pi;

  logic              stall_po;

  modport master (
    input  if_req_pi, if_addr_pi,
    input  d_req_pi, d_we_pi, d_addr_pi, d_wdata_pi,
    input  mem_rdata_pi, mem_ready_pi,
    output if_gnt_po, if_valid_po, if_rdata_po,
    output d_gnt_po, d_valid_po, d_rdata_po,
    output mem_en_po, mem_we_po, mem_addr_po, mem_wdata_po,
    output stall_po
  );

  modport slave (
    output if_req_pi, if_addr_pi,
    output d_req_pi, d_we_pi, d_addr_pi, d_wdata_pi,
    output mem_rdata_pi, mem_ready_pi,
    input  if_gnt_po, if_valid_po, if_rdata_po,
    input  d_gnt_po, d_valid_po, d_rdata_po,
    input  mem_en_po, mem_we_po, mem_addr_po, mem_wdata_po,
    input  stall_po
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one variable-latency memory port; data wins ties
// unless fetch has lost STARVE_MAX times in a row. MEM_PORT_ARBITER_PERF_EN adds perf counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk_pi,
  input  logic reset_pi,
`ifdef MEM_PORT_ARBITER_PERF_EN
  output logic [31:0] perf_if_wait_po,
  output logic [31:0] perf_d_cnt_po,
`endif
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic arb_pt, fetch_starved, pick_d, pick_if;

  always_comb begin
    // A busy cycle whose access completes is also an arbitration point,
    // so the next access starts without an idle bubble.
    arb_pt        = (state_q == IDLE) || bus.mem_ready_pi;
    fetch_starved = (starve_q >= STARVE_LIM);
    pick_d        = arb_pt && bus.d_req_pi && (!fetch_starved || !bus.if_req_pi);
    pick_if       = arb_pt && bus.if_req_pi && !pick_d;

    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if (pick_d) begin
      state_d     = BUSY_D;
      mem_addr_d  = bus.d_addr_pi;
      mem_wdata_d = bus.d_wdata_pi;
      mem_we_d    = bus.d_we_pi;
    end else if (pick_if) begin
      state_d    = BUSY_IF;
      mem_addr_d = bus.if_addr_pi;
      mem_we_d   = 1'b0;
    end else if (arb_pt) begin
      state_d  = IDLE;
      mem_we_d = 1'b0;
    end
    mem_en_d = (state_d != IDLE);

    if_valid_d = (state_q == BUSY_IF) && bus.mem_ready_pi;
    d_valid_d  = (state_q == BUSY_D) && bus.mem_ready_pi;
    if_rdata_d = if_valid_d ? bus.mem_rdata_pi : if_rdata_q;
    // Store completions leave the last loaded word in place.
    d_rdata_d  = (d_valid_d && !mem_we_q) ? bus.mem_rdata_pi : d_rdata_q;

    starve_d = starve_q;
    if (!bus.if_req_pi || pick_if) begin
      starve_d = 4'd0;
    end else if (pick_d && !fetch_starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_pi or negedge reset_pi) begin
    if (!reset_pi) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_gnt_po    = pick_if;
  assign bus.d_gnt_po     = pick_d;
  assign bus.if_valid_po  = if_valid_q;
  assign bus.d_valid_po   = d_valid_q;
  assign bus.if_rdata_po  = if_rdata_q;
  assign bus.d_rdata_po   = d_rdata_q;
  assign bus.mem_en_po    = mem_en_q;
  assign bus.mem_we_po    = mem_we_q && mem_en_q;
  assign bus.mem_addr_po  = mem_addr_q;
  assign bus.mem_wdata_po = mem_wdata_q;
  assign bus.stall_po     = (state_q != IDLE) || bus.if_req_pi || bus.d_req_pi;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_if_wait_q, perf_if_wait_d;
  logic [31:0] perf_d_cnt_q, perf_d_cnt_d;

  always_comb begin
    perf_if_wait_d = perf_if_wait_q + ((bus.if_req_pi && !pick_if) ? 32'd1 : 32'd0);
    perf_d_cnt_d   = perf_d_cnt_q + (pick_d ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_pi or negedge reset_pi) begin
    if (!reset_pi) begin
      perf_if_wait_q <= '0;
      perf_d_cnt_q   <= '0;
    end else begin
      perf_if_wait_q <= perf_if_wait_d;
      perf_d_cnt_q   <= perf_d_cnt_d;
    end
  end

  assign perf_if_wait_po = perf_if_wait_q;
  assign perf_d_cnt_po   = perf_d_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard queue per requester is
// filled at issue time and drained by a monitor on every valid pulse.
module tb_mem_port_arbiter;

  logic clk_pi = 1'b0;
  logic reset_pi = 1'b0;
  always #5 clk_pi = ~clk_pi;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_if_wait, perf_d_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk_pi   (clk_pi),
    .reset_pi (reset_pi),
`ifdef MEM_PORT_ARBITER_PERF_EN
    .perf_if_wait_po (perf_if_wait),
    .perf_d_cnt_po   (perf_d_cnt),
`endif
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] exp_d_last = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model with a programmable number of wait cycles.
  logic [31:0] mem [logic [31:0]];
  int wait_cfg = 0;
  int wcnt = 0;

  always @(posedge clk_pi) begin
    #1;
    if (bus.mem_en_po) begin
      if (wcnt == wait_cfg) begin
        bus.mem_ready_pi = 1'b1;
        bus.mem_rdata_pi = mem.exists(bus.mem_addr_po) ? mem[bus.mem_addr_po] : 32'h0;
        if (bus.mem_we_po) mem[bus.mem_addr_po] = bus.mem_wdata_po;
        wcnt = 0;
      end else begin
        bus.mem_ready_pi = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ready_pi = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk_pi) begin
    if (bus.if_valid_po) begin
      if (if_q.size() == 0) check("if_valid_unexpected", 32'd1, 32'd0);
      else check("if_rdata", bus.if_rdata_po, if_q.pop_front());
    end
    if (bus.d_valid_po) begin
      if (d_q.size() == 0) check("d_valid_unexpected", 32'd1, 32'd0);
      else check("d_rdata", bus.d_rdata_po, d_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req_pi = 0; bus.if_addr_pi = 0;
    bus.d_req_pi = 0; bus.d_we_pi = 0; bus.d_addr_pi = 0; bus.d_wdata_pi = 0;
    bus.mem_ready_pi = 0; bus.mem_rdata_pi = 0;
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h14] = 32'h12345678;
    mem[32'h34] = 32'h0BADF00D;
    mem[32'h40] = 32'hCAFE0040;
    mem[32'h44] = 32'h44444444;

    // Reset state
    repeat (2) @(negedge clk_pi);
    check("rst_mem_en", {31'd0, bus.mem_en_po}, 0);
    check("rst_mem_we", {31'd0, bus.mem_we_po}, 0);
    check("rst_mem_addr", bus.mem_addr_po, 0);
    check("rst_if_rdata", bus.if_rdata_po, 0);
    check("rst_d_rdata", bus.d_rdata_po, 0);
    check("rst_stall", {31'd0, bus.stall_po}, 0);
    @(posedge clk_pi); #1; reset_pi = 1;

    // Single fetch, zero wait
    @(posedge clk_pi); #1;
    bus.if_req_pi = 1; bus.if_addr_pi = 32'h10; if_q.push_back(32'hDEADBEEF);
    @(negedge clk_pi);
    check("t1_if_gnt", {31'd0, bus.if_gnt_po}, 1);
    check("t1_stall", {31'd0, bus.stall_po}, 1);
    @(posedge clk_pi); #1; bus.if_req_pi = 0;
    @(negedge clk_pi);
    check("t1_mem_en", {31'd0, bus.mem_en_po}, 1);
    check("t1_mem_addr", bus.mem_addr_po, 32'h10);
    check("t1_mem_we", {31'd0, bus.mem_we_po}, 0);
    @(negedge clk_pi);
    check("t1_if_valid", {31'd0, bus.if_valid_po}, 1);
    @(negedge clk_pi);
    check("t1_stall_low", {31'd0, bus.stall_po}, 0);

    // Simultaneous store and fetch: data first, fetch back-to-back
    @(posedge clk_pi); #1;
    bus.if_req_pi = 1; bus.if_addr_pi = 32'h14;
    bus.d_req_pi = 1; bus.d_we_pi = 1; bus.d_addr_pi = 32'h20; bus.d_wdata_pi = 32'h55;
    d_q.push_back(exp_d_last);
    if_q.push_back(32'h12345678);
    @(negedge clk_pi);
    check("t2_d_gnt", {31'd0, bus.d_gnt_po}, 1);
    check("t2_if_gnt_wait", {31'd0, bus.if_gnt_po}, 0);
    @(posedge clk_pi); #1; bus.d_req_pi = 0; bus.d_we_pi = 0;
    @(negedge clk_pi);
    check("t2_mem_we", {31'd0, bus.mem_we_po}, 1);
    check("t2_mem_wdata", bus.mem_wdata_po, 32'h55);
    check("t2_mem_addr", bus.mem_addr_po, 32'h20);
    check("t2_if_gnt_on_ready", {31'd0, bus.if_gnt_po}, 1);
    @(posedge clk_pi); #1; bus.if_req_pi = 0;
    @(negedge clk_pi);
    check("t2_no_bubble", {31'd0, bus.mem_en_po}, 1);
    check("t2_fetch_addr", bus.mem_addr_po, 32'h14);
    check("t2_fetch_we", {31'd0, bus.mem_we_po}, 0);
    check("t2_d_valid", {31'd0, bus.d_valid_po}, 1);
    repeat (2) @(negedge clk_pi);

    // Starvation: continuous requests, every fifth grant goes to fetch
    @(posedge clk_pi); #1;
    bus.if_req_pi = 1; bus.if_addr_pi = 32'h34;
    bus.d_req_pi = 1; bus.d_we_pi = 0; bus.d_addr_pi = 32'h20;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_pi);
      if (k % 5 == 4) begin
        check("t3_grant_sel", {30'd0, bus.if_gnt_po, bus.d_gnt_po}, 32'd2);
        if_q.push_back(32'h0BADF00D);
      end else begin
        check("t3_grant_sel", {30'd0, bus.if_gnt_po, bus.d_gnt_po}, 32'd1);
        d_q.push_back(32'h55);
        exp_d_last = 32'h55;
      end
    end
    @(posedge clk_pi); #1; bus.if_req_pi = 0; bus.d_req_pi = 0;
    repeat (3) @(negedge clk_pi);

    // Load with three wait cycles
    wait_cfg = 3;
    @(posedge clk_pi); #1;
    bus.d_req_pi = 1; bus.d_we_pi = 0; bus.d_addr_pi = 32'h40;
    d_q.push_back(32'hCAFE0040); exp_d_last = 32'hCAFE0040;
    @(negedge clk_pi);
    check("t4_d_gnt", {31'd0, bus.d_gnt_po}, 1);
    @(posedge clk_pi); #1; bus.d_req_pi = 0; bus.d_addr_pi = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_pi);
      check("t4_mem_en_hold", {31'd0, bus.mem_en_po}, 1);
      check("t4_mem_addr_hold", bus.mem_addr_po, 32'h40);
      check("t4_no_early_valid", {31'd0, bus.d_valid_po}, 0);
    end
    @(negedge clk_pi);
    check("t4_d_valid", {31'd0, bus.d_valid_po}, 1);
    check("t4_mem_en_off", {31'd0, bus.mem_en_po}, 0);
    @(negedge clk_pi);
    check("t4_single_valid", {31'd0, bus.d_valid_po}, 0);
    check("t4_rdata_hold", bus.d_rdata_po, 32'hCAFE0040);

    // Reset in the middle of a data access
    @(posedge clk_pi); #1;
    bus.d_req_pi = 1; bus.d_we_pi = 0; bus.d_addr_pi = 32'h44;
    @(negedge clk_pi);
    check("t5_d_gnt", {31'd0, bus.d_gnt_po}, 1);
    @(posedge clk_pi); #1; bus.d_req_pi = 0;
    @(negedge clk_pi);
    check("t5_busy", {31'd0, bus.mem_en_po}, 1);
    @(posedge clk_pi); #1; reset_pi = 0; #1;
    check("t5_rst_mem_en", {31'd0, bus.mem_en_po}, 0);
    check("t5_rst_mem_addr", bus.mem_addr_po, 0);
    check("t5_rst_d_rdata", bus.d_rdata_po, 0);
    check("t5_rst_if_rdata", bus.if_rdata_po, 0);
    check("t5_rst_stall", {31'd0, bus.stall_po}, 0);
    exp_d_last = 32'h0;
    @(posedge clk_pi); #1; reset_pi = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_pi);
      check("t5_no_d_valid", {31'd0, bus.d_valid_po}, 0);
    end
    wait_cfg = 0;
    @(posedge clk_pi); #1;
    bus.if_req_pi = 1; bus.if_addr_pi = 32'h10; if_q.push_back(32'hDEADBEEF);
    @(negedge clk_pi);
    check("t5_clean_gnt", {31'd0, bus.if_gnt_po}, 1);
    @(posedge clk_pi); #1; bus.if_req_pi = 0;
    @(negedge clk_pi);
    check("t5_clean_mem_addr", bus.mem_addr_po, 32'h10);
    @(negedge clk_pi);
    check("t5_clean_valid", {31'd0, bus.if_valid_po}, 1);
    repeat (2) @(negedge clk_pi);

`ifdef MEM_PORT_ARBITER_PERF_EN
    // Fetch blocked behind a two-wait data load
    wait_cfg = 2;
    @(posedge clk_pi); #1;
    bus.if_req_pi = 1; bus.if_addr_pi = 32'h10;
    bus.d_req_pi = 1; bus.d_we_pi = 0; bus.d_addr_pi = 32'h40;
    d_q.push_back(32'hCAFE0040); exp_d_last = 32'hCAFE0040;
    if_q.push_back(32'hDEADBEEF);
    @(posedge clk_pi); #1; bus.d_req_pi = 0;
    repeat (2) @(negedge clk_pi);
    @(negedge clk_pi);
    check("t6_if_gnt", {31'd0, bus.if_gnt_po}, 1);
    @(posedge clk_pi); #1; bus.if_req_pi = 0;
    repeat (4) @(negedge clk_pi);
    check("t6_perf_if_wait", perf_if_wait, 32'd3);
    check("t6_perf_d_cnt", perf_d_cnt, 32'd1);
    wait_cfg = 0;
`endif

    repeat (4) @(negedge clk_pi);
    check("end_if_q_empty", if_q.size(), 0);
    check("end_d_q_empty", d_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch requester (PC/insMem side) and the data requester (load/store side).
- Serialises accesses through a req/gnt/valid handshake.
- Data accesses win ties, with starvation protection for fetch.
- Drives a stall to the processor top level while any access is outstanding, so the datapath can freeze PC and register writes.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win; legal range 1..15.

Ports:
- clk_pi  in  1  clock; all state changes on its rising edge.
- reset_pi  in  1  asynchronous, active-low reset.
- if_req_pi  in  1  fetch request; held high until if_gnt_po.
- if_addr_pi  in  ADDR_W  fetch address.
- if_gnt_po  out  1  fetch request accepted this cycle.
- if_valid_po  out  1  one-cycle pulse; fetch data on if_rdata_po.
- if_rdata_po  out  DATA_W  last fetched word.
- d_req_pi  in  1  data request; held high until d_gnt_po.
- d_we_pi  in  1  1 = store, 0 = load.
- d_addr_pi  in  ADDR_W  data address.
- d_wdata_pi  in  DATA_W  store data.
- d_gnt_po  out  1  data request accepted this cycle.
- d_valid_po  out  1  one-cycle pulse; load data ready or store complete.
- d_rdata_po  out  DATA_W  last loaded word.
- mem_en_po  out  1  memory access active.
- mem_we_po  out  1  memory write strobe.
- mem_addr_po  out  ADDR_W  memory address.
- mem_wdata_po  out  DATA_W  memory write data.
- mem_rdata_pi  in  DATA_W  memory read data, valid with mem_ready_pi.
- mem_ready_pi  in  1  memory completes the current access this cycle.
- stall_po  out  1  processor must hold state.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_D.
- Reset (reset_pi low, asynchronous):
  - State goes to IDLE and the starvation counter to 0.
  - All outputs go to 0, including rdata registers and mem_* lines.
  - Any in-flight access is abandoned; no valid pulse is produced for it.
- Arbitration point: any cycle in IDLE, or a BUSY cycle with mem_ready_pi = 1 (back-to-back, no bubble).
- At an arbitration point, selection is:
  - data if d_req_pi and starve_cnt < STARVE_MAX;
  - otherwise fetch if if_req_pi;
  - otherwise data if d_req_pi;
  - otherwise none, and the next state is IDLE.
- Grant timing:
  - gnt is combinational, asserted in the selection cycle.
  - addr, wdata and we are registered on that edge into mem_addr_po, mem_wdata_po and mem_we_po.
  - mem_en_po = 1 from the next cycle.
  - The requester may drop req or change addr the cycle after gnt.
- Starvation counter (4-bit):
  - Increments when if_req_pi = 1 and data wins an arbitration point.
  - Clears on any fetch grant, or when if_req_pi = 0.
  - Saturates at STARVE_MAX.
- In BUSY_x:
  - mem_en_po, mem_addr_po, mem_we_po and mem_wdata_po are held stable until mem_ready_pi.
  - On mem_ready_pi, mem_rdata_pi is registered into the owner's rdata and the owner's valid pulses for exactly 1 cycle, the cycle after ready.
  - Store completion pulses d_valid_po and leaves d_rdata_po unchanged.
- Latency: gnt edge → mem_en_po next cycle → valid the cycle after mem_ready_pi. Minimum request-to-valid is 2 cycles when mem_ready_pi is high on the first mem_en_po cycle.
- mem_ready_pi in IDLE is ignored.
- mem_we_po is forced 0 whenever mem_en_po = 0.
- stall_po = (state != IDLE) | if_req_pi | d_req_pi, registered-free (combinational).
- Simultaneous fetch and data requests: data is granted first; fetch is granted at the next arbitration point unless data requests again and starve_cnt < STARVE_MAX.
- A request that drops before gnt is a protocol violation; the arbiter simply does not serve it.
- There is no valid pulse without a prior gnt.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined: adds outputs perf_if_wait_po [31:0] and perf_d_cnt_po [31:0], both reset to 0.
  - perf_if_wait_po counts cycles with if_req_pi = 1 and if_gnt_po = 0.
  - perf_d_cnt_po counts d_gnt_po pulses.
  - Both wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single fetch, addr 0x10, memory ready on first cycle returning 0xDEADBEEF:
  - if_gnt_po at cycle 0;
  - mem_en_po and mem_addr_po = 0x10 at cycle 1;
  - if_valid_po with if_rdata_po = 0xDEADBEEF at cycle 2;
  - stall_po low at cycle 3.
- if_req_pi and d_req_pi (store 0x20 ← 0x55) in the same cycle:
  - d_gnt_po first, with mem_we_po = 1 and mem_wdata_po = 0x55;
  - if_gnt_po on the cycle of mem_ready_pi;
  - no IDLE bubble between the two accesses.
- Continuous d_req_pi plus if_req_pi with STARVE_MAX = 4: four data grants, then one fetch grant, repeating; if_gnt_po every 5th grant.
- Memory with 3 wait cycles on a load of 0x40: mem_addr_po and mem_en_po stay stable for 4 cycles; a single d_valid_po; d_rdata_po holds its value afterwards.
- reset_pi low mid-BUSY_D: outputs go to 0 immediately, no d_valid_po, next access starts cleanly from IDLE.
- With MEM_PORT_ARBITER_PERF_EN defined, fetch blocked 3 cycles behind a data access: perf_if_wait_po = 3 and perf_d_cnt_po = 1.
